iob_clint_ticker: RTL

Hardware bus initiator that drives an `iob_clint` over the IOb native interface so that one hart gets a drift-free periodic timer tick without CPU involvement. It reads `mtime` tear-free and programs `mtimecmp[HART]` to `mtime + period`. On every `mtip` it emits a one-cycle `tick` and reprograms `mtimecmp += period`. It sits beside the CPU as a second initiator on the CLINT port (through the system arbiter) or directly on a dedicated CLINT.

---
 rtl/iob_clint_pkg.sv | 24 ++
 rtl/iob_clint_ticker_if.sv | 30 +++
 rtl/iob_native_master.sv | 48 ++++
 rtl/iob_clint_ticker.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/iob_clint_pkg.sv
// CLINT register map shared by iob_clint and its bus initiators, plus the ticker FSM states.
package iob_clint_pkg;

   localparam logic [15:0] MSIP_BASE     = 16'h0000;
   localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
   localparam logic [15:0] MTIME_BASE    = 16'hBFF8;

   typedef enum logic [3:0] {
      StIdle,
      StRdHi0,
      StRdLo,
      StRdHi1,
      StCalc,
      StWrHiMax,
      StWrLo,
      StWrHi,
      StArmed
   } tick_state_e;

   function automatic logic [15:0] mtimecmp_addr(input int unsigned hart);
      return MTIMECMP_BASE + 16'(8 * hart);
   endfunction

endpackage

// File: rtl/iob_clint_ticker_if.sv
// IOb native bus between the ticker (initiator) and the CLINT (responder).
interface iob_clint_ticker_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 32
);
   logic                  valid;
   logic [ADDR_W-1:0]     address;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic [DATA_W-1:0]     rdata;
   logic                  ready;

   modport master (
      output valid,
      output address,
      output wdata,
      output wstrb,
      input  rdata,
      input  ready
   );

   modport slave (
      input  valid,
      input  address,
      input  wdata,
      input  wstrb,
      output rdata,
      output ready
   );
endinterface

// File: rtl/iob_native_master.sv
// Single-transaction IOb initiator: holds valid until ready, then leaves one idle cycle.
module iob_native_master #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req,
   input  logic                 we,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [DATA_W-1:0]    wdat,
   output logic                 done,
   output logic [DATA_W-1:0]    rdat,
   iob_clint_ticker_if.master   bus
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic                valid_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]   wstrb_q;

   // A new request is only taken from a cycle with valid low, so dropping valid on the
   // accepting edge guarantees the idle gap the lagging ready needs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else if (valid_q) begin
         if (bus.ready) valid_q <= 1'b0;
      end else if (req) begin
         valid_q <= 1'b1;
         addr_q  <= addr;
         wdata_q <= we ? wdat : '0;
         wstrb_q <= we ? '1 : '0;
      end
   end

   assign done        = valid_q & bus.ready;
   assign rdat        = bus.rdata;
   assign bus.valid   = valid_q;
   assign bus.address = addr_q;
   assign bus.wdata   = wdata_q;
   assign bus.wstrb   = wstrb_q;

endmodule

// File: rtl/iob_clint_ticker.sv
// Drift-free periodic timer tick: reads mtime tear-free, arms mtimecmp[HART] and rearms on mtip.
module iob_clint_ticker
   import iob_clint_pkg::*;
#(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned HART     = 0,
   parameter int unsigned PERIOD_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   input  logic                mtip_in,
   iob_clint_ticker_if.master  bus,
   output logic                tick,
   output logic                busy,
   output logic [31:0]         tick_cnt
);
   if (DATA_W != 32) begin : g_bad_data_w
      $error("iob_clint_ticker: only DATA_W = 32 is supported");
   end

   localparam logic [ADDR_W-1:0] MTIME_LO = ADDR_W'(MTIME_BASE);
   localparam logic [ADDR_W-1:0] MTIME_HI = ADDR_W'(MTIME_BASE + 16'd4);
   localparam logic [ADDR_W-1:0] CMP_LO   = ADDR_W'(mtimecmp_addr(HART));
   localparam logic [ADDR_W-1:0] CMP_HI   = ADDR_W'(mtimecmp_addr(HART) + 16'd4);

   tick_state_e           state_q, state_d;
   logic [PERIOD_W-1:0]   per_q;
   logic [31:0]           hi0_q, lo_q, hi1_q;
   logic [63:0]           cmp_q;
   logic [31:0]           tick_cnt_q;

   logic                  req, we, done;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdat, rdat;

   iob_native_master #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_master (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .we   (we),
      .addr (addr),
      .wdat (wdat),
      .done (done),
      .rdat (rdat),
      .bus  (bus)
   );

   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      we      = 1'b0;
      addr    = '0;
      wdat    = '0;
      tick    = 1'b0;
      unique case (state_q)
         StIdle: if (enable && (period != '0)) state_d = StRdHi0;
         StRdHi0: begin
            req  = 1'b1;
            addr = MTIME_HI;
            if (done) state_d = enable ? StRdLo : StIdle;
         end
         StRdLo: begin
            req  = 1'b1;
            addr = MTIME_LO;
            if (done) state_d = enable ? StRdHi1 : StIdle;
         end
         StRdHi1: begin
            req  = 1'b1;
            addr = MTIME_HI;
            if (done) begin
               if (!enable)             state_d = StIdle;
               else if (rdat != hi0_q)  state_d = StRdHi0;
               else                     state_d = StCalc;
            end
         end
         StCalc: state_d = enable ? StWrHiMax : StIdle;
         // Parking hi at all-ones first keeps mtip low while lo is being replaced.
         StWrHiMax: begin
            req  = 1'b1;
            we   = 1'b1;
            addr = CMP_HI;
            wdat = '1;
            if (done) state_d = enable ? StWrLo : StIdle;
         end
         StWrLo: begin
            req  = 1'b1;
            we   = 1'b1;
            addr = CMP_LO;
            wdat = cmp_q[31:0];
            if (done) state_d = enable ? StWrHi : StIdle;
         end
         StWrHi: begin
            req  = 1'b1;
            we   = 1'b1;
            addr = CMP_HI;
            wdat = cmp_q[63:32];
            if (done) state_d = enable ? StArmed : StIdle;
         end
         StArmed: begin
            if (!enable) begin
               state_d = StIdle;
            end else if (mtip_in) begin
               tick    = 1'b1;
               state_d = StWrHiMax;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         per_q      <= '0;
         hi0_q      <= '0;
         lo_q       <= '0;
         hi1_q      <= '0;
         cmp_q      <= '0;
         tick_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && state_d == StRdHi0) per_q <= period;
         if (done && state_q == StRdHi0) hi0_q <= rdat;
         if (done && state_q == StRdLo)  lo_q  <= rdat;
         if (done && state_q == StRdHi1) hi1_q <= rdat;
         if (state_q == StCalc) cmp_q <= {hi1_q, lo_q} + 64'(per_q);
         if (tick) begin
            cmp_q      <= cmp_q + 64'(per_q);
            tick_cnt_q <= tick_cnt_q + 32'd1;
         end
      end
   end

   assign busy     = (state_q != StIdle) && (state_q != StArmed);
   assign tick_cnt = tick_cnt_q;

endmodule
